// File: rtl/mem_arbiter.sv
// mem_arbiter: N-master to single-slave memory arbiter, one outstanding transaction.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  localparam int ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req_valid,
  output logic [NUM_MASTERS-1:0]            m_req_ready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]            m_wen,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wmask,
  output logic [NUM_MASTERS-1:0]            m_resp_valid,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              s_req_valid,
  input  logic                              s_req_ready,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic                              s_wen,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [DATA_WIDTH/8-1:0]           s_wmask,
  input  logic                              s_resp_valid,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  output logic [ID_W-1:0]                   grant_id,
  output logic                              busy
);
  localparam int MW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] winner;
  logic any;
  logic grant;
  logic done;
`ifdef MEM_ARB_RR_EN
  logic [ID_W-1:0] last_grant;
  // search begins just after the previous winner and wraps
  always_comb begin
    winner = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!any && m_req_valid[(int'(last_grant) + k) % NUM_MASTERS]) begin
        any = 1'b1;
        winner = ID_W'((int'(last_grant) + k) % NUM_MASTERS);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) last_grant <= ID_W'(NUM_MASTERS - 1);
    else if (grant) last_grant <= winner;
  end
`else
  always_comb begin
    winner = '0;
    any = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (m_req_valid[k]) begin
        any = 1'b1;
        winner = ID_W'(k);
      end
    end
  end
`endif
  always_comb begin
    grant = (state == IDLE) && any;
    done = (state == RESP) && s_resp_valid;
    state_n = grant ? REQ : (state == REQ && s_req_ready) ? RESP : done ? IDLE : state;
    m_req_ready = grant ? NUM_MASTERS'(1) << winner : '0;
    s_req_valid = state == REQ;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      s_addr <= '0;
      s_wen <= 1'b0;
      s_wdata <= '0;
      s_wmask <= '0;
      m_rdata <= '0;
      m_resp_valid <= '0;
    end else begin
      state <= state_n;
      m_resp_valid <= done ? NUM_MASTERS'(1) << grant_id : '0;
      if (done) m_rdata <= s_rdata;
      if (grant) begin
        grant_id <= winner;
        s_addr <= m_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        s_wen <= m_wen[winner];
        s_wdata <= m_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        s_wmask <= m_wmask[int'(winner)*MW +: MW];
      end
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- N-master to single-slave memory arbiter.
- Successor to the fixed two-port IFU/LSU memory path: generalises to NUM_MASTERS requesters with configurable address/data width.
- Each master and the slave use a valid/ready request channel plus a response-valid pulse.
- Sits between the fetch, load-store and future DMA/debug requesters and the single memory slave. Allows one outstanding transaction at a time.

## Interface

Parameters:
- NUM_MASTERS, 2, number of requesters (1..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8)
- ID_W (localparam), max(1, $clog2(NUM_MASTERS)), grant index width

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- m_req_valid  in  NUM_MASTERS  per-master request valid
- m_req_ready  out  NUM_MASTERS  per-master request accepted (one-hot or zero)
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wen  in  NUM_MASTERS  per-master write enable
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_wmask  in  NUM_MASTERS*DATA_WIDTH/8  packed byte masks
- m_resp_valid  out  NUM_MASTERS  one-cycle response pulse to the granted master
- m_rdata  out  DATA_WIDTH  response data, broadcast to all masters
- s_req_valid  out  1  slave request valid
- s_req_ready  in  1  slave request accept
- s_addr / s_wen / s_wdata / s_wmask  out  ADDR_WIDTH / 1 / DATA_WIDTH / DATA_WIDTH/8  latched request payload
- s_resp_valid  in  1  slave response pulse
- s_rdata  in  DATA_WIDTH  slave read data
- grant_id  out  ID_W  index of the current/last granted master
- busy  out  1  high in REQ and RESP

## Operation

- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Combinationally pick winner g among m_req_valid and assert m_req_ready[g] only.
  - At the clock edge, latch addr/wen/wdata/wmask of g into the payload registers, set grant_id=g, go to REQ.
  - With no request, stay in IDLE.
- REQ:
  - s_req_valid=1 and the slave outputs carry the latched payload, stable until accepted.
  - On s_req_ready=1, go to RESP.
  - s_resp_valid is ignored in REQ; the slave must respond no earlier than the cycle after accept.
- RESP:
  - Wait for s_resp_valid.
  - On s_resp_valid, register m_rdata<=s_rdata, pulse m_resp_valid[grant_id] for exactly the next cycle, go to IDLE.
  - Writes also complete via s_resp_valid; m_rdata is then don't-care and passes s_rdata.
- m_req_ready is zero in REQ/RESP. A master keeps m_req_valid and payload stable until it sees m_req_ready.
- s_resp_valid in IDLE is ignored and produces no master pulse.
- Arbitration:
  - Round-robin pointer last_grant, updated on each grant.
  - Search starts at (last_grant+1) mod NUM_MASTERS and wraps at NUM_MASTERS-1→0.
- NUM_MASTERS=1: arbiter degenerates to a pass-through with the same FSM; grant_id=0.

## Timing

- Reset (rst=1 at a posedge):
  - state=IDLE, last_grant=NUM_MASTERS-1, grant_id=0.
  - s_req_valid=0, s_addr/s_wdata/s_wmask/s_wen=0, m_rdata=0, m_resp_valid=0, busy=0.
  - m_req_ready is combinational and may be high in the cycle after reset.
- Reset mid-transaction: abandon the transaction. No m_resp_valid is issued, and a later stray s_resp_valid is ignored in IDLE.
- Minimum latency with a zero-wait slave:
  - cycle 0: m_req_ready.
  - cycle 1: s_req_valid with s_req_ready.
  - cycle 2: s_resp_valid.
  - cycle 3: m_resp_valid.
- Back-to-back: the cycle m_resp_valid is high, the FSM is already in IDLE, so the next grant occurs in the same cycle (throughput: one transaction per 3 cycles minimum).
- Simultaneous requests: exactly one grant per IDLE cycle; losers hold valid and are served in later rounds.

## Configuration

- MEM_ARB_RR_EN defined: round-robin arbitration as above. No master waits more than NUM_MASTERS-1 grants while holding valid.
- MEM_ARB_RR_EN undefined: fixed priority, lowest index wins; last_grant logic removed; grant_id still reports the winner.

## Test plan

- Reset, then master 1 reads addr 0x8000_0010, slave returns 0xDEADBEEF one cycle after accept:
  - m_req_ready=0b10 at cycle 0; s_addr=0x8000_0010, s_wen=0 at cycle 1.
  - m_resp_valid=0b10 and m_rdata=0xDEADBEEF at cycle 3.
- All of masters 0,1,2 (NUM_MASTERS=3) continuously valid, RR build:
  - grant order 0,1,2,0,1,2.
  - Fixed-priority build: 0,0,0…
- Master 0 writes wdata=0x12345678, wmask=0b0011, slave holds s_req_ready=0 for 4 cycles:
  - s_req_valid and payload stable all 4 cycles.
  - Exactly one m_resp_valid[0] pulse after s_resp_valid.
- rst asserted while in RESP, then a stray s_resp_valid arrives:
  - all outputs return to reset values.
  - no m_resp_valid is generated.
- s_resp_valid driven while in IDLE and in REQ: no state change, m_resp_valid stays 0.
- Master 2 drops valid before its grant while master 0 is valid: master 0 is granted next; grant_id never shows 2.
